// File: rtl/axis_keep_packer_pkg.sv
// axis_pack_pkg: shared types and helpers for the AXI4-Stream keep packer.
package axis_pack_pkg;

    localparam int MAXB = 8;

    typedef logic [7:0] byte_t;
    typedef logic [3:0] pcnt_t;

    function automatic bit bytes_ok(int b);
        return b == 2 || b == 4 || b == 8;
    endfunction

    function automatic pcnt_t popcount_keep(logic [MAXB-1:0] k);
        pcnt_t n;
        n = '0;
        for (int i = 0; i < MAXB; i++) n = n + pcnt_t'(k[i]);
        return n;
    endfunction

    // For c == MAXB the shift wraps to 0 and the decrement yields all ones.
    function automatic logic [MAXB-1:0] last_keep(pcnt_t c);
        return (MAXB'(1) << c) - MAXB'(1);
    endfunction

endpackage

// File: rtl/axis_keep_packer_if.sv
// axis_keep_packer_if: AXI4-Stream bundle (tdata/tkeep/tlast/tvalid/tready).
//   master: drives tdata, tkeep, tlast, tvalid; samples tready
//   slave : samples tdata, tkeep, tlast, tvalid; drives tready
interface axis_keep_packer_if #(parameter int BYTES = 4) ();

    logic [8*BYTES-1:0] tdata;
    logic [BYTES-1:0]   tkeep;
    logic               tlast;
    logic               tvalid;
    logic               tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);

endinterface

// File: rtl/axis_keep_packer_compactor.sv
// keep_compactor: packs tkeep-qualified bytes to low lanes in ascending order.
//   tdata/tkeep : input beat
//   pk_o        : packed bytes, unused entries 0
//   count_o     : number of kept bytes
module keep_compactor
    import axis_pack_pkg::*;
#(
    parameter int BYTES = 4
) (
    input  logic [8*BYTES-1:0] tdata,
    input  logic [BYTES-1:0]   tkeep,
    output byte_t              pk_o [BYTES],
    output pcnt_t              count_o
);

    logic [MAXB-1:0] kpad;

    always_comb begin
        pcnt_t pos;
        pos = '0;
        kpad = '0;
        kpad[BYTES-1:0] = tkeep;
        for (int j = 0; j < BYTES; j++) pk_o[j] = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (tkeep[i]) begin
                for (int j = 0; j < BYTES; j++)
                    if (pos == pcnt_t'(j)) pk_o[j] = tdata[8*i +: 8];
                pos = pos + pcnt_t'(1);
            end
        end
        count_o = popcount_keep(kpad);
    end

endmodule

// File: rtl/axis_keep_packer.sv
// axis_keep_packer: compacts sparse-tkeep AXI4-Stream beats into dense beats.
//   aclk, aresetn : clock, synchronous active-low reset
//   s_axis        : sparse input stream (slave)
//   m_axis        : dense output stream (master), full beats plus one
//                   low-justified partial beat at tlast; all outputs registered
module axis_keep_packer
    import axis_pack_pkg::*;
#(
    parameter int BYTES = 4
) (
    input  logic               aclk,
    input  logic               aresetn,
    axis_keep_packer_if.slave  s_axis,
    axis_keep_packer_if.master m_axis
);

    localparam int NB = 2 * BYTES;
    localparam int CW = $clog2(NB) + 1;
    typedef logic [CW-1:0] cnt_t;

    if (!bytes_ok(BYTES)) begin : g_bad_bytes
        $error("axis_keep_packer: BYTES must be 2, 4 or 8");
    end

    byte_t              buf_q [NB];
    byte_t              buf_d [NB];
    cnt_t               cnt_q, cnt_d, pop, cnt_mid;
    logic               flush_q, flush_d;
    logic               s_tready_q, s_tready_d;
    logic               m_tvalid_q, m_tvalid_d;
    logic               m_tlast_q, m_tlast_d;
    logic [BYTES-1:0]   m_tkeep_q, m_tkeep_d;
    logic [8*BYTES-1:0] m_tdata_q, m_tdata_d;
    logic               acc, m_hs;
    logic [MAXB-1:0]    lk;
    byte_t              pk [BYTES];
    pcnt_t              n_in;

    keep_compactor #(.BYTES(BYTES)) u_cmp (
        .tdata   (s_axis.tdata),
        .tkeep   (s_axis.tkeep),
        .pk_o    (pk),
        .count_o (n_in)
    );

    // Bytes above cnt are kept at zero, so the shift fills with zeros and
    // output lanes outside tkeep read back as 0 without extra masking.
    always_comb begin
        acc = s_axis.tvalid && s_tready_q;
        m_hs = m_tvalid_q && m_axis.tready;
        pop = m_hs ? ((cnt_q > cnt_t'(BYTES)) ? cnt_t'(BYTES) : cnt_q) : '0;
        cnt_mid = cnt_q - pop;
        for (int i = 0; i < NB; i++) begin
            buf_d[i] = '0;
            for (int p = 0; p <= BYTES; p++)
                if (int'(pop) == p && i + p < NB) buf_d[i] = buf_q[(i + p) % NB];
            for (int j = 0; j < BYTES; j++)
                if (acc && pcnt_t'(j) < n_in && int'(cnt_mid) + j == i) buf_d[i] = pk[j];
        end
        cnt_d = cnt_mid + (acc ? cnt_t'(n_in) : '0);
        // Set and clear cannot coincide: input is blocked while flushing.
        flush_d = (m_hs && m_tlast_q) ? 1'b0 : (flush_q || (acc && s_axis.tlast));
        s_tready_d = !flush_d && cnt_d <= cnt_t'(BYTES);
        m_tvalid_d = cnt_d >= cnt_t'(BYTES) || flush_d;
        m_tlast_d = flush_d && cnt_d <= cnt_t'(BYTES);
        lk = last_keep(pcnt_t'(cnt_d));
        m_tkeep_d = !m_tvalid_d ? '0 : m_tlast_d ? lk[BYTES-1:0] : '1;
        for (int i = 0; i < BYTES; i++) m_tdata_d[8*i +: 8] = buf_d[i];
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            buf_q      <= '{default: '0};
            cnt_q      <= '0;
            flush_q    <= 1'b0;
            s_tready_q <= 1'b0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tkeep_q  <= '0;
            m_tdata_q  <= '0;
        end else begin
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            s_tready_q <= s_tready_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            m_tkeep_q  <= m_tkeep_d;
            m_tdata_q  <= m_tdata_d;
        end
    end

    assign s_axis.tready = s_tready_q;
    assign m_axis.tvalid = m_tvalid_q;
    assign m_axis.tlast  = m_tlast_q;
    assign m_axis.tkeep  = m_tkeep_q;
    assign m_axis.tdata  = m_tdata_q;

endmodule
